// File: rtl/traffic_light_ctrl_param_if.sv
// Lamp-controller port bundle: operator inputs, registered lamp/segment outputs
// and a debug view of the phase FSM.
// There is no handshake here: ped_req and night_mode are level inputs sampled
// every clock, and all outputs are plain registered levels.
interface traffic_light_ctrl_param_if #(
  parameter int PWM_BITS = 4
);
  logic                ped_req;
  logic                night_mode;
  logic [PWM_BITS-1:0] pwm_duty;
  logic                led_r;
  logic                led_y;
  logic                led_g;
  logic                walk;
  logic                pwm_out;
  logic [6:0]          seg;
  logic [1:0]          dbg_state;
  logic [3:0]          dbg_remaining;

  modport master (
    output ped_req, night_mode, pwm_duty,
    input  led_r, led_y, led_g, walk, pwm_out, seg, dbg_state, dbg_remaining
  );

  modport slave (
    input  ped_req, night_mode, pwm_duty,
    output led_r, led_y, led_g, walk, pwm_out, seg, dbg_state, dbg_remaining
  );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// Single-intersection RED->GREEN->YELLOW controller with pedestrian request,
// night flashing-yellow mode, PWM lamp dimming and a 7-segment countdown.
module traffic_light_ctrl_param #(
  parameter int TICK_DIV = 10_000_000,
  parameter int T_RED    = 5,
  parameter int T_GREEN  = 7,
  parameter int T_YELLOW = 2,
  parameter int T_GMIN   = 2,
  parameter int PWM_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  traffic_light_ctrl_param_if.slave    tl
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  localparam int              PS_W      = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [3:0]      R_RED     = 4'(T_RED);
  localparam logic [3:0]      R_GREEN   = 4'(T_GREEN);
  localparam logic [3:0]      R_YELLOW  = 4'(T_YELLOW);
  localparam logic [3:0]      R_GMIN    = 4'(T_GMIN);

  state_t              state, state_n;
  logic [3:0]          remaining, remaining_n;
  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pending, pending_n;
  logic                served, served_n;
  logic                blink, blink_n;
  logic                tick;
  logic                pwm_on;

  logic                lamp_r, lamp_y, lamp_g, lamp_walk;
  logic [6:0]          seg_digit;

  logic                led_r_q, led_y_q, led_g_q, walk_q, pwm_out_q;
  logic [6:0]          seg_q;

  assign tick   = (prescaler == TICK_LAST);
  assign pwm_on = (pwm_cnt < tl.pwm_duty);

  // Prescaler and PWM counter free-run; only reset realigns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RED;
      remaining <= R_RED;
      pending   <= 1'b0;
      served    <= 1'b0;
      blink     <= 1'b1;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      pending   <= pending_n;
      served    <= served_n;
      blink     <= blink_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    pending_n   = pending;
    served_n    = served;
    blink_n     = blink;
    if (state != S_FLASH && tl.night_mode) begin
      // Night entry wins over any phase advance due in this same cycle.
      state_n   = S_FLASH;
      blink_n   = 1'b1;
      pending_n = 1'b0;
      served_n  = 1'b0;
    end else if (state == S_FLASH) begin
      if (!tl.night_mode) begin
        state_n     = S_RED;
        remaining_n = R_RED;
      end else if (tick) begin
        blink_n = ~blink;
      end
    end else begin
      pending_n = pending | tl.ped_req;
      if (tick) begin
        if (remaining == 4'd1) begin
          case (state)
            S_RED: begin
              state_n     = S_GREEN;
              remaining_n = R_GREEN;
              served_n    = 1'b0;
            end
            S_GREEN: begin
              state_n     = S_YELLOW;
              remaining_n = R_YELLOW;
            end
            default: begin
              // A press landing on the YELLOW->RED edge belongs to the next cycle.
              state_n     = S_RED;
              remaining_n = R_RED;
              served_n    = pending;
              pending_n   = tl.ped_req;
            end
          endcase
        end else if (state == S_GREEN && pending && (remaining - 4'd1) > R_GMIN) begin
          remaining_n = R_GMIN;
        end else begin
          remaining_n = remaining - 4'd1;
        end
      end
    end
  end

  always_comb begin
    lamp_r    = 1'b0;
    lamp_y    = 1'b0;
    lamp_g    = 1'b0;
    lamp_walk = 1'b0;
    case (state)
      S_RED: begin
        lamp_r    = 1'b1;
        lamp_walk = served;
      end
      S_GREEN:  lamp_g = 1'b1;
      S_YELLOW: lamp_y = 1'b1;
      default:  lamp_y = blink;
    endcase
  end

  always_comb begin
    seg_digit = 7'h00;
    if (state != S_FLASH) begin
      case (remaining)
        4'd1:    seg_digit = 7'h06;
        4'd2:    seg_digit = 7'h5B;
        4'd3:    seg_digit = 7'h4F;
        4'd4:    seg_digit = 7'h66;
        4'd5:    seg_digit = 7'h6D;
        4'd6:    seg_digit = 7'h7D;
        4'd7:    seg_digit = 7'h07;
        4'd8:    seg_digit = 7'h7F;
        4'd9:    seg_digit = 7'h6F;
        default: seg_digit = 7'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_r_q   <= 1'b0;
      led_y_q   <= 1'b0;
      led_g_q   <= 1'b0;
      walk_q    <= 1'b0;
      pwm_out_q <= 1'b0;
      seg_q     <= 7'h00;
    end else begin
      led_r_q   <= lamp_r & pwm_on;
      led_y_q   <= lamp_y & pwm_on;
      led_g_q   <= lamp_g & pwm_on;
      walk_q    <= lamp_walk;
      pwm_out_q <= pwm_on;
      seg_q     <= seg_digit;
    end
  end

  assign tl.led_r         = led_r_q;
  assign tl.led_y         = led_y_q;
  assign tl.led_g         = led_g_q;
  assign tl.walk          = walk_q;
  assign tl.pwm_out       = pwm_out_q;
  assign tl.seg           = seg_q;
  assign tl.dbg_state     = state;
  assign tl.dbg_remaining = remaining;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench for traffic_light_ctrl_param with TICK_DIV=4, T_RED=3,
// T_GREEN=5, T_YELLOW=2, T_GMIN=2; every phase is a multiple of 4 cycles.
module tb_traffic_light_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-tick schedule entry: {walk, phase[1:0], rem_or_blink[3:0]}.
  // phase 0=RED 1=GREEN 2=YELLOW 3=FLASH (low bit = blink).
  logic [6:0]  sched[$];
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  traffic_light_ctrl_param_if #(.PWM_BITS(4)) tl ();

  traffic_light_ctrl_param #(
    .TICK_DIV (4),
    .T_RED    (3),
    .T_GREEN  (5),
    .T_YELLOW (2),
    .T_GMIN   (2),
    .PWM_BITS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tl  (tl)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected {pwm_out, led_r, led_y, led_g, walk, seg} for internal cycle c.
  function automatic logic [11:0] exp_vec(input logic [6:0] s, input int c, input logic [3:0] duty);
    logic       pw, r, y, g, w;
    logic [6:0] sg;
    pw = (c % 16) < int'(duty);
    r  = 1'b0;
    y  = 1'b0;
    g  = 1'b0;
    w  = s[6];
    sg = seg_of(s[3:0]);
    case (s[5:4])
      2'd0:    r = pw;
      2'd1:    g = pw;
      2'd2:    y = pw;
      default: begin
        y  = s[0] & pw;
        w  = 1'b0;
        sg = 7'h00;
      end
    endcase
    return {pw, r, y, g, w, sg};
  endfunction

  function automatic logic [11:0] observed();
    return {tl.pwm_out, tl.led_r, tl.led_y, tl.led_g, tl.walk, tl.seg};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    tl.ped_req    = 1'b0;
    tl.night_mode = 1'b0;
    tl.pwm_duty   = 4'd15;
    step();
    step();
  endtask

  // Duty a for cycles below switch_c, duty b from then on.
  task automatic build_exp(input logic [3:0] duty_a, input logic [3:0] duty_b, input int switch_c);
    exp_q.delete();
    for (int c = 0; c < sched.size() * 4; c++)
      exp_q.push_back(exp_vec(sched[c / 4], c, (c < switch_c) ? duty_a : duty_b));
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    apply_reset();
    obs = observed();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 12'h000);
    end
    n_checks++;
    if (tl.dbg_state !== 2'd0 || tl.dbg_remaining !== 4'd3) begin
      n_fail++;
      $display("FAIL reset_state got=%0d/%0d exp=0/3", tl.dbg_state, tl.dbg_remaining);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal_cycle();
    logic [11:0] obs, expv;
    int nc;
    apply_reset();
    rst   = 1'b0;
    sched = '{7'h03, 7'h02, 7'h01, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11, 7'h22, 7'h21,
              7'h03, 7'h02, 7'h01, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11, 7'h22, 7'h21};
    build_exp(4'd15, 4'd15, 0);
    nc = exp_q.size();
    for (int n = 1; n <= nc; n++) begin
      step();
      expv = exp_q.pop_front();
      obs  = observed();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL normal_cycle c=%0d got=%h exp=%h", n - 1, obs, expv);
      end
    end
  endtask

  task automatic test_ped_shorten();
    logic [11:0] obs, expv;
    int nc;
    apply_reset();
    rst   = 1'b0;
    sched = '{7'h03, 7'h02, 7'h01, 7'h15, 7'h12, 7'h11, 7'h22, 7'h21,
              7'h43, 7'h42, 7'h41, 7'h15, 7'h14, 7'h13};
    build_exp(4'd15, 4'd15, 0);
    nc = exp_q.size();
    for (int n = 1; n <= nc; n++) begin
      tl.ped_req = (n - 1 == 12);
      step();
      expv = exp_q.pop_front();
      obs  = observed();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL ped_shorten c=%0d got=%h exp=%h", n - 1, obs, expv);
      end
    end
    tl.ped_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] obs, expv;
    int nc;
    apply_reset();
    rst   = 1'b0;
    sched = '{7'h03, 7'h02, 7'h01, 7'h15, 7'h12, 7'h11, 7'h22, 7'h21,
              7'h43, 7'h42, 7'h41, 7'h15, 7'h12, 7'h11, 7'h22, 7'h21,
              7'h43, 7'h42, 7'h41, 7'h15, 7'h12, 7'h11};
    build_exp(4'd15, 4'd15, 0);
    nc = exp_q.size();
    for (int n = 1; n <= nc; n++) begin
      tl.ped_req = (n - 1 == 12) || (n - 1 == 36) || (n - 1 == 63);
      step();
      expv = exp_q.pop_front();
      obs  = observed();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d got=%h exp=%h", n - 1, obs, expv);
      end
    end
    tl.ped_req = 1'b0;
  endtask

  task automatic test_night();
    logic [11:0] obs, expv;
    int nc;
    apply_reset();
    rst   = 1'b0;
    sched = '{7'h03, 7'h02, 7'h01, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11,
              7'h31, 7'h30, 7'h31, 7'h30, 7'h31, 7'h30,
              7'h03, 7'h02, 7'h01, 7'h15, 7'h14};
    build_exp(4'd15, 4'd15, 0);
    nc = exp_q.size();
    for (int n = 1; n <= nc; n++) begin
      tl.night_mode = (n - 1 >= 31) && (n - 1 <= 54);
      tl.ped_req    = (n - 1 == 40);
      step();
      expv = exp_q.pop_front();
      obs  = observed();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL night c=%0d got=%h exp=%h", n - 1, obs, expv);
      end
      if (n == 33) begin
        n_checks++;
        if (tl.dbg_state !== 2'd3) begin
          n_fail++;
          $display("FAIL night_state got=%0d exp=3", tl.dbg_state);
        end
      end
    end
    tl.night_mode = 1'b0;
    tl.ped_req    = 1'b0;
  endtask

  task automatic test_pwm();
    logic [11:0] obs, expv;
    int nc;
    apply_reset();
    rst   = 1'b0;
    sched = '{7'h03, 7'h02, 7'h01, 7'h15, 7'h12, 7'h11, 7'h22, 7'h21,
              7'h43, 7'h42, 7'h41, 7'h15, 7'h14, 7'h13};
    build_exp(4'd4, 4'd0, 32);
    nc = exp_q.size();
    for (int n = 1; n <= nc; n++) begin
      tl.pwm_duty = (n - 1 < 32) ? 4'd4 : 4'd0;
      tl.ped_req  = (n - 1 == 12);
      step();
      expv = exp_q.pop_front();
      obs  = observed();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL pwm c=%0d got=%h exp=%h", n - 1, obs, expv);
      end
    end
    tl.ped_req  = 1'b0;
    tl.pwm_duty = 4'd15;
  endtask

  task automatic test_reset_mid_yellow();
    logic [11:0] obs, expv;
    int nc;
    apply_reset();
    rst   = 1'b0;
    sched = '{7'h03, 7'h02, 7'h01, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11, 7'h22};
    build_exp(4'd15, 4'd15, 0);
    for (int n = 1; n <= 34; n++) begin
      step();
      expv = exp_q.pop_front();
      obs  = observed();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL pre_reset c=%0d got=%h exp=%h", n - 1, obs, expv);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs = observed();
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got=%h exp=%h", obs, 12'h000);
    end
    sched = '{7'h03, 7'h02, 7'h01, 7'h15, 7'h14};
    build_exp(4'd15, 4'd15, 0);
    nc = exp_q.size();
    for (int n = 1; n <= nc; n++) begin
      step();
      expv = exp_q.pop_front();
      obs  = observed();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL post_reset c=%0d got=%h exp=%h", n - 1, obs, expv);
      end
    end
  endtask

  initial begin
    tl.ped_req    = 1'b0;
    tl.night_mode = 1'b0;
    tl.pwm_duty   = 4'd15;
    test_reset();
    test_normal_cycle();
    test_ped_shorten();
    test_back_to_back();
    test_night();
    test_pwm();
    test_reset_mid_yellow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
